// File: rtl/mat_tx_arbiter.sv
// mat_tx_arbiter: round-robin dump of two matrix memories through one UART transmitter.
// Define MAT_TX_TIMEOUT_EN to abort a byte (err pulse) when tx_busy never rises within TIMEOUT cycles.
module mat_tx_arbiter #(
  parameter int ROWS = 2,
  parameter int COLS = 2,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  output logic [1:0]        mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data0,
  input  logic [DATA_W-1:0] mem_data1,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_byte,
  input  logic              tx_busy,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [1:0]        done,
  output logic              err
);
  localparam int N = ROWS * COLS;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [2:0] {IDLE, READ, LOAD, SEND, WAIT_IDLE, DONE} state_t;
  state_t state, state_n;
  logic [1:0] r1, r2, rise, pending, pending_n, grant_n;
  logic last, last_n, tmo, term;
  logic [CW-1:0] cnt, cnt_n;
`ifdef MAT_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  assign tmo = state == SEND && !tx_busy && tcnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk)
    if (rst) begin
      tcnt <= '0;
      err <= 1'b0;
    end else begin
      tcnt <= state == SEND ? tcnt + 1'b1 : '0;
      err <= tmo;
    end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif
  assign rise = r1 & ~r2;
  assign term = cnt == CW'(N - 1);
  assign mem_rd = state == READ ? grant : 2'b00;
  assign mem_addr = state == READ ? ADDR_W'(cnt) : '0;
  assign tx_start = state == SEND;
  assign busy = state != IDLE;
  assign done = state == DONE ? grant : 2'b00;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    grant_n = grant;
    last_n = last;
    pending_n = pending;
    case (state)
      IDLE: if (|pending) begin
        grant_n = pending == 2'b11 ? (last ? 2'b01 : 2'b10) : pending;
        cnt_n = '0;
        state_n = READ;
      end
      READ: state_n = LOAD;
      LOAD: state_n = SEND;
      SEND: state_n = tx_busy ? WAIT_IDLE : tmo ? IDLE : SEND;
      WAIT_IDLE: if (!tx_busy) begin
        state_n = term ? DONE : READ;
        cnt_n = term ? cnt : cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (state == DONE || tmo) begin
      pending_n = pending & ~grant;
      last_n = grant[1];
      grant_n = 2'b00;
    end
    // a re-request from the owner is ignored, except on the DONE cycle where it re-queues
    pending_n = pending_n | (rise & (state == DONE ? 2'b11 : ~grant));
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      r1 <= '0;
      r2 <= '0;
      pending <= '0;
      last <= 1'b1;
      cnt <= '0;
      grant <= '0;
      tx_byte <= '0;
    end else begin
      state <= state_n;
      r1 <= req;
      r2 <= r1;
      pending <= pending_n;
      last <= last_n;
      cnt <= cnt_n;
      grant <= grant_n;
      if (state == LOAD) tx_byte <= grant[1] ? mem_data1 : mem_data0;
    end
endmodule

// File: tb/tb_mat_tx_arbiter.sv
// tb_mat_tx_arbiter: randomized dumps checked against a transfer-level model of the arbiter.
module tb_mat_tx_arbiter;
  logic clk, rst, tx_start, tx_busy, busy, err;
  logic [1:0] req, mem_rd, grant, done;
  logic [5:0] mem_addr;
  logic [7:0] mem_data0, mem_data1, tx_byte;
  logic [7:0] mem [2][4];
  int checks, errors, max_dly, rst_cnt, stab_bad, dg_bad, last_m;
  int rd_src_q[$], rd_addr_q[$], src_q[$], done_q[$], grant_q[$];
  logic [7:0] byte_q[$];

  mat_tx_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data0(mem_data0), .mem_data1(mem_data1), .tx_start(tx_start), .tx_byte(tx_byte),
    .tx_busy(tx_busy), .grant(grant), .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memories with one-cycle read latency plus a bus monitor
  initial begin
    logic [1:0] pg;
    mem_data0 = '0;
    mem_data1 = '0;
    dg_bad = 0;
    pg = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_rd[0]) mem_data0 = mem[0][mem_addr[1:0]];
        if (mem_rd[1]) mem_data1 = mem[1][mem_addr[1:0]];
        if (|mem_rd) begin
          rd_src_q.push_back(mem_rd == 2'b10 ? 1 : mem_rd == 2'b01 ? 0 : 9);
          rd_addr_q.push_back(int'(mem_addr));
        end
        if (|done) begin
          done_q.push_back(int'(done));
          if (done != grant) dg_bad++;
        end
        if (grant != pg && grant != 0) grant_q.push_back(int'(grant));
      end
      pg = grant;
    end
  end

  // transmitter: random delay before busy rises, then busy held a few cycles
  initial begin
    int d, ep;
    logic [7:0] b;
    tx_busy = 0;
    stab_bad = 0;
    forever begin
      @(negedge clk);
      if (tx_start && !rst) begin
        d = $urandom_range(0, max_dly);
        ep = rst_cnt;
        b = tx_byte;
        repeat (d) begin
          @(negedge clk);
          if (ep == rst_cnt && (!tx_start || tx_byte != b || mem_rd != 0)) stab_bad++;
        end
        tx_busy = 1;
        src_q.push_back(grant[1] ? 1 : 0);
        byte_q.push_back(b);
        repeat ($urandom_range(3, 20)) begin
          @(negedge clk);
          if (ep == rst_cnt && tx_byte != b) stab_bad++;
        end
        tx_busy = 0;
      end
    end
  end

  task automatic run(input logic [1:0] mask, input bit inject);
    int order[$];
    int rb, bb, db, gb, sb, t, n;
    rb = rd_src_q.size();
    bb = byte_q.size();
    db = done_q.size();
    gb = grant_q.size();
    sb = stab_bad + dg_bad;
    foreach (mem[i, j]) mem[i][j] = 8'($urandom);
    if (mask == 2'b11) begin
      order.push_back(last_m ? 0 : 1);
      order.push_back(last_m ? 1 : 0);
    end else order.push_back(mask[1] ? 1 : 0);
    if (inject) order.push_back(0);
    req = mask;
    if (inject) begin
      t = 0;
      while (byte_q.size() == bb && t < 1000) begin
        @(negedge clk);
        t++;
      end
      req = 2'b00;
      repeat (2) @(negedge clk);
      req = 2'b11;
    end
    t = 0;
    while ((done_q.size() - db < order.size() || busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("finish", int'(t < 5000), 1);
    repeat (30) @(negedge clk);
    n = order.size();
    check("n_done", done_q.size() - db, n);
    check("n_grant", grant_q.size() - gb, n);
    check("n_bytes", byte_q.size() - bb, 4 * n);
    check("n_reads", rd_src_q.size() - rb, 4 * n);
    check("stable", stab_bad + dg_bad - sb, 0);
    for (int k = 0; k < n; k++)
      if (done_q.size() > db + k && grant_q.size() > gb + k) begin
        check("done", done_q[db + k], 1 << order[k]);
        check("grant", grant_q[gb + k], 1 << order[k]);
      end
    for (int k = 0; k < 4 * n; k++)
      if (byte_q.size() > bb + k && rd_src_q.size() > rb + k) begin
        check("rd_src", rd_src_q[rb + k], order[k / 4]);
        check("rd_addr", rd_addr_q[rb + k], k % 4);
        check("tx_src", src_q[bb + k], order[k / 4]);
        check("tx_byte", byte_q[bb + k], mem[order[k / 4]][k % 4]);
      end
    last_m = order[n - 1];
    req = 2'b00;
    repeat (4) @(negedge clk);
  endtask

  task automatic reset_mid();
    int bb, db, t;
    bb = byte_q.size();
    db = done_q.size();
    foreach (mem[i, j]) mem[i][j] = 8'($urandom);
    req = 2'b10;
    t = 0;
    while (!(byte_q.size() >= bb + 2 && tx_busy) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("reach_wait", int'(t < 2000), 1);
    @(negedge clk);
    rst_cnt++;
    rst = 1;
    req = 2'b00;
    @(negedge clk);
    check("rst_outs", 32'({mem_rd, mem_addr, tx_start, tx_byte, grant, busy, done, err}), 0);
    rst = 0;
    check("rst_bytes", byte_q.size() - bb, 2);
    check("rst_done", done_q.size() - db, 0);
    t = 0;
    while (tx_busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    check("rst_idle", 32'({busy, tx_start, mem_rd, grant}), 0);
    last_m = 1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1;
    req = 0;
    max_dly = 3;
    rst_cnt = 0;
    last_m = 1;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({mem_rd, mem_addr, tx_start, tx_byte, grant, busy, done, err}), 0);
    rst = 0;
    repeat (2) @(negedge clk);
    run(2'b10, 0);
    run(2'b11, 0);
    run(2'b10, 1);
    max_dly = 40;
    run(2'b01, 0);
    max_dly = 3;
    reset_mid();
    run(2'b11, 0);
    for (int i = 0; i < 4; i++) begin
      max_dly = $urandom_range(0, 12);
      run(2'($urandom_range(1, 3)), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
